// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and the memory (slave).
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, variable-latency imem request, IF/ID register.
// A redirect during an outstanding fetch parks the target and drains the stale response.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pc_write,
  input  logic                     IF_ID_write,
  input  logic                     flush,
  input  logic [31:0]              redirect_pc,
  if_fetch_stage_if.master         imem,
  output logic [31:0]              IF_ID_pc_plus4,
  output logic [31:0]              IF_ID_instr,
  output logic                     IF_ID_valid,
  output logic                     fetch_busy
);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pending_pc_reg, pending_pc_next;
  logic [31:0] if_id_pc_plus4_reg, if_id_pc_plus4_next;
  logic [31:0] if_id_instr_reg, if_id_instr_next;
  logic        if_id_valid_reg, if_id_valid_next;

  logic        redirect;
  logic [31:0] pc_plus4;

  // A flush under a load-use stall is ignored: the branch compare used stale operands.
  assign redirect = flush && pc_write;
  assign pc_plus4 = pc_reg + 32'd4;

  // The request is held high whenever out of reset; the address is the PC in both states.
  assign imem.imem_req  = rst;
  assign imem.imem_addr = pc_reg;

  assign fetch_busy = (state_reg == FETCH) && imem.imem_req && !imem.imem_ready;

  assign IF_ID_pc_plus4 = if_id_pc_plus4_reg;
  assign IF_ID_instr    = if_id_instr_reg;
  assign IF_ID_valid    = if_id_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= FETCH;
      pc_reg             <= RESET_PC;
      pending_pc_reg     <= 32'h0000_0000;
      if_id_pc_plus4_reg <= 32'h0000_0000;
      if_id_instr_reg    <= NOP_INSTR;
      if_id_valid_reg    <= 1'b0;
    end else begin
      state_reg          <= state_next;
      pc_reg             <= pc_next;
      pending_pc_reg     <= pending_pc_next;
      if_id_pc_plus4_reg <= if_id_pc_plus4_next;
      if_id_instr_reg    <= if_id_instr_next;
      if_id_valid_reg    <= if_id_valid_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    pc_next             = pc_reg;
    pending_pc_next     = pending_pc_reg;
    if_id_pc_plus4_next = if_id_pc_plus4_reg;
    if_id_instr_next    = if_id_instr_reg;
    if_id_valid_next    = if_id_valid_reg;

    unique case (state_reg)
      FETCH: begin
        if (!pc_write) begin
          // Stalled: any returned word is dropped and the same PC is refetched.
          if (IF_ID_write) begin
            if_id_pc_plus4_next = 32'h0000_0000;
            if_id_instr_next    = NOP_INSTR;
            if_id_valid_next    = 1'b0;
          end
        end else if (redirect) begin
          if (IF_ID_write) begin
            if_id_pc_plus4_next = 32'h0000_0000;
            if_id_instr_next    = NOP_INSTR;
            if_id_valid_next    = 1'b0;
          end
          if (imem.imem_ready) begin
            pc_next = redirect_pc;
          end else begin
            pending_pc_next = redirect_pc;
            state_next      = DRAIN;
          end
        end else if (imem.imem_ready) begin
          pc_next = pc_plus4;
          if (IF_ID_write) begin
            if_id_pc_plus4_next = pc_plus4;
            if_id_instr_next    = imem.imem_rdata;
            if_id_valid_next    = 1'b1;
          end
        end else if (IF_ID_write) begin
          if_id_pc_plus4_next = 32'h0000_0000;
          if_id_instr_next    = NOP_INSTR;
          if_id_valid_next    = 1'b0;
        end
      end

      DRAIN: begin
        if (IF_ID_write) begin
          if_id_pc_plus4_next = 32'h0000_0000;
          if_id_instr_next    = NOP_INSTR;
          if_id_valid_next    = 1'b0;
        end
        // The newest redirect target wins, including one arriving with the stale response.
        if (imem.imem_ready) begin
          pc_next    = redirect ? redirect_pc : pending_pc_reg;
          state_next = FETCH;
        end else if (redirect) begin
          pending_pc_next = redirect_pc;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule
